// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and the data stage.
// Registered req/done handshake, read-data capture per owner, and an access watchdog.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    // A zero TIMEOUT still gets a 1-bit counter so the vector is never empty.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state,     w_nxt_state;
    logic          r_owner_d,   w_nxt_owner_d;
    logic          r_last_d,    w_nxt_last_d;
    logic [CW-1:0] r_wd_cnt,    w_nxt_wd_cnt;
    logic          r_if_gnt,    w_nxt_if_gnt;
    logic          r_d_gnt,     w_nxt_d_gnt;
    logic          r_if_done,   w_nxt_if_done;
    logic          r_d_done,    w_nxt_d_done;
    logic          r_err,       w_nxt_err;
    logic [DW-1:0] r_if_rdata,  w_nxt_if_rdata;
    logic [DW-1:0] r_d_rdata,   w_nxt_d_rdata;
    logic          r_mem_req,   w_nxt_mem_req;
    logic          r_mem_we,    w_nxt_mem_we;
    logic [AW-1:0] r_mem_addr,  w_nxt_mem_addr;
    logic [DW-1:0] r_mem_wdata, w_nxt_mem_wdata;
    logic          w_win_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_last_d    <= 1'b1;
            r_wd_cnt    <= '0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_owner_d   <= w_nxt_owner_d;
            r_last_d    <= w_nxt_last_d;
            r_wd_cnt    <= w_nxt_wd_cnt;
            r_if_gnt    <= w_nxt_if_gnt;
            r_d_gnt     <= w_nxt_d_gnt;
            r_if_done   <= w_nxt_if_done;
            r_d_done    <= w_nxt_d_done;
            r_err       <= w_nxt_err;
            r_if_rdata  <= w_nxt_if_rdata;
            r_d_rdata   <= w_nxt_d_rdata;
            r_mem_req   <= w_nxt_mem_req;
            r_mem_we    <= w_nxt_mem_we;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_owner_d   = r_owner_d;
        w_nxt_last_d    = r_last_d;
        w_nxt_wd_cnt    = r_wd_cnt;
        w_nxt_if_gnt    = r_if_gnt;
        w_nxt_d_gnt     = r_d_gnt;
        w_nxt_if_done   = r_if_done;
        w_nxt_d_done    = r_d_done;
        w_nxt_err       = r_err;
        w_nxt_if_rdata  = r_if_rdata;
        w_nxt_d_rdata   = r_d_rdata;
        w_nxt_mem_req   = r_mem_req;
        w_nxt_mem_we    = r_mem_we;
        w_nxt_mem_addr  = r_mem_addr;
        w_nxt_mem_wdata = r_mem_wdata;
        // On a tie the requester that did not go last wins.
        w_win_d         = d_req && (!if_req || !r_last_d);

        case (r_state)
            S_IDLE: begin
                w_nxt_wd_cnt = '0;
                if (if_req || d_req) begin
                    w_nxt_owner_d   = w_win_d;
                    w_nxt_last_d    = w_win_d;
                    w_nxt_mem_req   = 1'b1;
                    w_nxt_mem_we    = w_win_d && d_we;
                    w_nxt_mem_addr  = w_win_d ? d_addr : if_addr;
                    w_nxt_mem_wdata = w_win_d ? d_wdata : '0;
                    w_nxt_if_gnt    = !w_win_d;
                    w_nxt_d_gnt     = w_win_d;
                    w_nxt_state     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_wd_cnt != CNT_MAX) begin
                    w_nxt_wd_cnt = r_wd_cnt + 1'b1;
                end
                if (mem_ready) begin
                    if (r_owner_d) begin
                        w_nxt_d_rdata = mem_rdata;
                        w_nxt_d_done  = 1'b1;
                    end else begin
                        w_nxt_if_rdata = mem_rdata;
                        w_nxt_if_done  = 1'b1;
                    end
                    w_nxt_mem_req = 1'b0;
                    w_nxt_state   = S_RESP;
                end else if (TIMEOUT != 0 && r_wd_cnt == CNT_LAST) begin
                    w_nxt_d_done  = r_owner_d;
                    w_nxt_if_done = !r_owner_d;
                    w_nxt_err     = 1'b1;
                    w_nxt_mem_req = 1'b0;
                    w_nxt_state   = S_RESP;
                end
            end
            S_RESP: begin
                w_nxt_if_gnt  = 1'b0;
                w_nxt_d_gnt   = 1'b0;
                w_nxt_if_done = 1'b0;
                w_nxt_d_done  = 1'b0;
                w_nxt_err     = 1'b0;
                w_nxt_wd_cnt  = '0;
                w_nxt_state   = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign if_gnt    = r_if_gnt;
    assign if_rdata  = r_if_rdata;
    assign if_done   = r_if_done;
    assign d_gnt     = r_d_gnt;
    assign d_rdata   = r_d_rdata;
    assign d_done    = r_d_done;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
